// File: rtl/gpio_event_scheduler.sv
// Queues one press event per button, grants them round-robin and sends each one
// as a byte over a valid/ready handshake, with an optional idle gap after each send.
module gpio_event_scheduler #(
  parameter int         N_BTN      = 4,
  parameter logic [7:0] CODE_BASE  = 8'h30,
  parameter int         GAP_CYCLES = 0
) (
  input  logic             src_clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_pulse,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             ovr_clr,
  output logic [N_BTN-1:0] pending,
  output logic [N_BTN-1:0] overrun,
  output logic             busy
);

  localparam int IW = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  // state | meaning
  // IDLE  | waiting for a pending event to grant
  // SEND  | tx_valid held until the handshake
  // GAP   | pacing delay after a handshake
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    last_grant_q, last_grant_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [N_BTN-1:0] pending_q, pending_d;
  logic [N_BTN-1:0] overrun_q, overrun_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             busy_q, busy_d;

  logic             hs;
  logic [N_BTN-1:0] clr;
  logic             found;
  logic [IW-1:0]    scan_idx;
  logic [IW-1:0]    scan_g;

  // Round-robin search starting just above the last granted button.
  always_comb begin
    found    = 1'b0;
    scan_idx = '0;
    scan_g   = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      scan_idx = IW'((int'(last_grant_q) + k) % N_BTN);
      if (!found && pending_q[scan_idx]) begin
        found  = 1'b1;
        scan_g = scan_idx;
      end
    end
  end

  always_comb begin
    hs  = (state_q == SEND) && tx_valid_q && tx_ready;
    clr = '0;
    if (hs) clr[grant_q] = 1'b1;
    // A press in the clearing cycle re-queues the event instead of counting as an overrun.
    pending_d = btn_pulse | (pending_q & ~clr);
    overrun_d = (ovr_clr ? '0 : overrun_q) | (btn_pulse & pending_q & ~clr);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    gap_cnt_d    = gap_cnt_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d    = scan_g;
          tx_data_d  = CODE_BASE + 8'(scan_g);
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          tx_valid_d   = 1'b0;
          last_grant_d = grant_q;
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            gap_cnt_d = GW'(GAP_CYCLES);
            state_d   = GAP;
          end
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q - GW'(1);
        if (gap_cnt_q == GW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge src_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(N_BTN - 1);
      grant_q      <= '0;
      gap_cnt_q    <= '0;
      pending_q    <= '0;
      overrun_q    <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      gap_cnt_q    <= gap_cnt_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign pending  = pending_q;
  assign overrun  = overrun_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_gpio_event_scheduler.sv
// Directed bench for gpio_event_scheduler: a GAP_CYCLES=0 instance and a
// GAP_CYCLES=3 instance share the same stimulus.
module tb_gpio_event_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       tready;
  logic       oclr;

  logic       tx_valid, busy;
  logic [7:0] tx_data;
  logic [3:0] pending, overrun;

  logic       g_tx_valid, g_busy;
  logic [7:0] g_tx_data;
  logic [3:0] g_pending, g_overrun;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gpio_event_scheduler #(.N_BTN(4), .CODE_BASE(8'h30), .GAP_CYCLES(0)) dut (
    .src_clk(clk), .rst(rst), .btn_pulse(btn), .tx_ready(tready),
    .tx_valid(tx_valid), .tx_data(tx_data), .ovr_clr(oclr),
    .pending(pending), .overrun(overrun), .busy(busy));

  gpio_event_scheduler #(.N_BTN(4), .CODE_BASE(8'h30), .GAP_CYCLES(3)) dut_gap (
    .src_clk(clk), .rst(rst), .btn_pulse(btn), .tx_ready(tready),
    .tx_valid(g_tx_valid), .tx_data(g_tx_data), .ovr_clr(oclr),
    .pending(g_pending), .overrun(g_overrun), .busy(g_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; btn = '0; oclr = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = 4'b1111; tready = 1'b0; oclr = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0; btn = '0;
    n_vec++; if (pending !== 4'b0000) begin n_err++; $display("FAIL reset_pending got %b exp 0000", pending); end
    n_vec++; if (overrun !== 4'b0000) begin n_err++; $display("FAIL reset_overrun got %b exp 0000", overrun); end
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", tx_valid); end
    n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h exp 00", tx_data); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    tick();
    n_vec++; if (pending !== 4'b0000 || tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_idle got pend %b valid %b exp 0000 0", pending, tx_valid); end
  endtask

  task automatic test_single();
    tready = 1'b1;
    btn = 4'b0100; tick(); btn = '0;
    n_vec++; if (pending !== 4'b0100) begin n_err++; $display("FAIL single_pend got %b exp 0100", pending); end
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid got %b exp 0", tx_valid); end
    tick();
    n_vec++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b exp 1", tx_valid); end
    n_vec++; if (tx_data !== 8'h32) begin n_err++; $display("FAIL single_data got %h exp 32", tx_data); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got %b exp 1", busy); end
    tick();
    n_vec++; if (pending !== 4'b0000) begin n_err++; $display("FAIL single_clear got %b exp 0000", pending); end
    n_vec++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_done got valid %b busy %b exp 0 0", tx_valid, busy); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d;
    do_reset();
    tready = 1'b1;
    btn = 4'b1111; tick(); btn = '0;
    tick();
    for (int i = 0; i < 4; i++) begin
      exp_d = 8'h30 + 8'(i);
      n_vec++; if (tx_valid !== 1'b1 || tx_data !== exp_d) begin n_err++; $display("FAIL rr_byte%0d got valid %b data %h exp 1 %h", i, tx_valid, tx_data, exp_d); end
      tick();
      n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rr_gap%0d got valid %b exp 0", i, tx_valid); end
      tick();
    end
    btn = 4'b1001; tick(); btn = '0;
    tick();
    n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'h30) begin n_err++; $display("FAIL rr_wrap_first got valid %b data %h exp 1 30", tx_valid, tx_data); end
    tick();
    tick();
    n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'h33) begin n_err++; $display("FAIL rr_wrap_second got valid %b data %h exp 1 33", tx_valid, tx_data); end
    tick();
    n_vec++; if (pending !== 4'b0000) begin n_err++; $display("FAIL rr_drained got %b exp 0000", pending); end
  endtask

  task automatic test_backpressure();
    tready = 1'b0;
    btn = 4'b0010; tick(); btn = '0;
    tick();
    for (int i = 0; i < 10; i++) begin
      n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'h31) begin n_err++; $display("FAIL bp_hold%0d got valid %b data %h exp 1 31", i, tx_valid, tx_data); end
      btn = (i == 3) ? 4'b0010 : 4'b0000;
      tick();
    end
    btn = '0;
    n_vec++; if (overrun !== 4'b0010) begin n_err++; $display("FAIL bp_overrun got %b exp 0010", overrun); end
    n_vec++; if (pending !== 4'b0010) begin n_err++; $display("FAIL bp_pend got %b exp 0010", pending); end
    btn = 4'b0010; oclr = 1'b1; tick(); btn = '0; oclr = 1'b0;
    n_vec++; if (overrun !== 4'b0010) begin n_err++; $display("FAIL bp_clr_race got %b exp 0010", overrun); end
    oclr = 1'b1; tick(); oclr = 1'b0;
    n_vec++; if (overrun !== 4'b0000) begin n_err++; $display("FAIL bp_clr got %b exp 0000", overrun); end
    tready = 1'b1; tick();
    n_vec++; if (tx_valid !== 1'b0 || pending !== 4'b0000) begin n_err++; $display("FAIL bp_release got valid %b pend %b exp 0 0000", tx_valid, pending); end
  endtask

  task automatic test_gap();
    do_reset();
    tready = 1'b1;
    btn = 4'b0011; tick(); btn = '0;
    tick();
    n_vec++; if (g_tx_valid !== 1'b1 || g_tx_data !== 8'h30) begin n_err++; $display("FAIL gap_first got valid %b data %h exp 1 30", g_tx_valid, g_tx_data); end
    btn = 4'b0001; tick(); btn = '0;
    n_vec++; if (g_pending !== 4'b0011) begin n_err++; $display("FAIL gap_requeue got %b exp 0011", g_pending); end
    n_vec++; if (g_overrun !== 4'b0000) begin n_err++; $display("FAIL gap_no_ovr got %b exp 0000", g_overrun); end
    n_vec++; if (g_busy !== 1'b1) begin n_err++; $display("FAIL gap_busy got %b exp 1", g_busy); end
    for (int i = 1; i <= 4; i++) begin
      n_vec++; if (g_tx_valid !== 1'b0) begin n_err++; $display("FAIL gap_quiet_h%0d got %b exp 0", i, g_tx_valid); end
      tick();
    end
    n_vec++; if (g_tx_valid !== 1'b1 || g_tx_data !== 8'h31) begin n_err++; $display("FAIL gap_second got valid %b data %h exp 1 31", g_tx_valid, g_tx_data); end
    tick();
    n_vec++; if (g_pending !== 4'b0001) begin n_err++; $display("FAIL gap_left got %b exp 0001", g_pending); end
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    tready = 1'b0;
    btn = 4'b0110; tick(); btn = '0;
    tick();
    n_vec++; if (tx_valid !== 1'b1 || pending !== 4'b0110) begin n_err++; $display("FAIL rms_pre got valid %b pend %b exp 1 0110", tx_valid, pending); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rms_valid got %b exp 0", tx_valid); end
    n_vec++; if (pending !== 4'b0000) begin n_err++; $display("FAIL rms_pend got %b exp 0000", pending); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rms_busy got %b exp 0", busy); end
    tick();
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rms_no_resend got %b exp 0", tx_valid); end
  endtask

  initial begin
    rst = 1'b1; btn = '0; tready = 1'b0; oclr = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_gap();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
